// File: rtl/fp16_pkg.sv
// Shared half-precision field definitions, result struct and sequencer states.
// No logic, no latency, no backpressure.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    // Unnormalized mantissa: [13] carry, [12] hidden, [11:2] fraction, [1] guard, [0] sticky
    localparam int MANT_W = 14;
    // Internal exponent has headroom for 63 plus two increments
    localparam int IEXP_W = 7;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ROUND,
        WR_HI,
        WR_LO,
        DONE
    } state_t;

    function automatic fp16_t fp16_overflow(input logic sign, input logic saturate);
        fp16_t r;
        r.sign = sign;
        r.exp  = '1;
        r.frac = saturate ? '1 : '0;
        return r;
    endfunction

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even of a normalized (or denormal) mantissa into fp16 fields.
// Purely combinational, zero latency, no backpressure.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [MANT_W-2:0] mant,
    input  logic [IEXP_W-1:0] exp,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W-1:0]  exp_field,
    output logic              ovf
);

    logic              round_up;
    logic              hidden;
    logic [11:0]       sum;
    logic [IEXP_W-1:0] exp_adj;

    always_comb begin
        round_up = mant[1] & (mant[0] | mant[2]);
        sum      = {1'b0, mant[12:2]} + {11'd0, round_up};
        if (sum[11]) begin
            // all-ones significand rounded past the hidden bit
            frac    = sum[10:1];
            hidden  = 1'b1;
            exp_adj = exp + IEXP_W'(1);
        end else begin
            frac    = sum[9:0];
            hidden  = sum[10];
            exp_adj = exp;
        end
        ovf       = (exp_adj >= IEXP_W'(31));
        exp_field = hidden ? exp_adj[EXP_W-1:0] : '0;
    end

endmodule

// File: rtl/fp16_norm_pack.sv
// Normalize (one bit per cycle), round RNE, pack fp16 and write it big-endian as two bytes.
// Latency N+4 cycles accept-to-done (N = NORM cycles), 4 for a zero mantissa.
// Accepts only when idle; in_valid is ignored while busy.
module fp16_norm_pack
    import fp16_pkg::*;
#(
    parameter int RES_ADDR = 12,
    parameter int ADDR_W   = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [5:0]        in_exp,
    input  logic [13:0]       in_mant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [15:0]       result,
    output logic              done
);

    state_t            state, state_nxt;
    logic              sign_r, sign_nxt;
    logic [IEXP_W-1:0] exp_r, exp_nxt;
    logic [MANT_W-1:0] mant_r, mant_nxt;
    fp16_t             res_r, res_nxt;

    logic [FRAC_W-1:0] rnd_frac;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_ovf;

    fp16_round_rne u_round (
        .mant      (mant_r[MANT_W-2:0]),
        .exp       (exp_r),
        .frac      (rnd_frac),
        .exp_field (rnd_exp),
        .ovf       (rnd_ovf)
    );

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_r;
        exp_nxt   = exp_r;
        mant_nxt  = mant_r;
        res_nxt   = res_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt  = in_sign;
                    exp_nxt   = {1'b0, in_exp};
                    mant_nxt  = in_mant;
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (mant_r == '0) begin
                    // exact zero is always +0
                    res_nxt   = '0;
                    state_nxt = WR_HI;
                end else if (mant_r[13]) begin
                    mant_nxt  = {1'b0, mant_r[13:2], mant_r[1] | mant_r[0]};
                    exp_nxt   = exp_r + IEXP_W'(1);
                    state_nxt = ROUND;
                end else if (!mant_r[12] && (exp_r != '0)) begin
                    mant_nxt  = {mant_r[12:0], 1'b0};
                    exp_nxt   = exp_r - IEXP_W'(1);
                end else begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (rnd_ovf) begin
                    res_nxt = fp16_overflow(sign_r, SATURATE);
                end else begin
                    res_nxt.sign = sign_r;
                    res_nxt.exp  = rnd_exp;
                    res_nxt.frac = rnd_frac;
                end
                state_nxt = WR_HI;
            end
            WR_HI:   state_nxt = WR_LO;
            WR_LO:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            res_r     <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            sign_r   <= sign_nxt;
            exp_r    <= exp_nxt;
            mant_r   <= mant_nxt;
            res_r    <= res_nxt;
            in_ready <= (state_nxt == IDLE);
            // memory port and done are decoded from the current state, one cycle behind it
            mem_we   <= (state == WR_HI) || (state == WR_LO);
            done     <= (state == DONE);
            case (state)
                WR_HI: begin
                    mem_addr  <= ADDR_W'(RES_ADDR);
                    mem_wdata <= res_r[15:8];
                end
                WR_LO: begin
                    mem_addr  <= ADDR_W'(RES_ADDR + 1);
                    mem_wdata <= res_r[7:0];
                end
                default: begin
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

    assign result = res_r;

endmodule

// File: tb/tb_fp16_norm_pack.sv
// Bench for fp16_norm_pack: directed table, reset-abort sequence and random ops vs a reference model.
module tb_fp16_norm_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sign;
    logic [5:0]  in_exp;
    logic [13:0] in_mant;

    logic        in_ready, mem_we, done;
    logic [7:0]  mem_addr, mem_wdata;
    logic [15:0] result;

    logic        in_ready0, mem_we0, done0;
    logic [7:0]  mem_addr0, mem_wdata0;
    logic [15:0] result0;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    logic [7:0] mem_img [0:255];

    always #5 clk = ~clk;

    fp16_norm_pack #(.RES_ADDR(12), .ADDR_W(8), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .result(result), .done(done)
    );

    fp16_norm_pack #(.RES_ADDR(12), .ADDR_W(8), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .result(result0), .done(done0)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem_img[mem_addr] = mem_wdata;
            wr_cnt++;
        end
    end

    typedef struct {
        string       name;
        logic        s;
        logic [5:0]  e;
        logic [13:0] m;
        logic [15:0] r_sat;
        logic [15:0] r_nosat;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: find the leading one directly, shift in one go, round on integers.
    function automatic void model(input bit s, input int e, input int m, input bit sat,
                                  output logic [15:0] r, output int lat);
        int p, sh, ee, mm, q, rem;
        if (m == 0) begin
            r   = 16'h0000;
            lat = 4;
            return;
        end
        if (m >= 8192) begin
            mm  = (m >> 1) | (m & 1);
            ee  = e + 1;
            lat = 5;
        end else begin
            p = 12;
            while (((m >> p) & 1) == 0) p--;
            sh  = 12 - p;
            if (sh > e) sh = e;
            mm  = m << sh;
            ee  = e - sh;
            lat = sh + 5;
        end
        q   = mm >> 2;
        rem = mm & 3;
        if (rem == 3 || (rem == 2 && (q & 1) == 1)) q++;
        if (q >= 2048) begin
            q = q >> 1;
            ee++;
        end
        if (ee >= 31)
            r = {s, 5'h1F, sat ? 10'h3FF : 10'h000};
        else
            r = {s, (q >= 1024) ? ee[4:0] : 5'd0, q[9:0]};
    endfunction

    task automatic run_op(input string name, input logic s, input logic [5:0] e, input logic [13:0] m,
                          input logic [15:0] r_sat, input logic [15:0] r_nosat, input int lat);
        int  waited, cyc;
        bit  rdy_low, seen;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            tick;
            waited++;
        end
        check({name, " ready_before"}, 32'(in_ready), 32'd1);
        wr_cnt      = 0;
        mem_img[12] = 8'h00;
        mem_img[13] = 8'h00;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        tick;
        // keep in_valid high with junk operands while busy: it must be ignored
        in_sign = 1'($urandom);
        in_exp  = 6'($urandom);
        in_mant = 14'($urandom);
        cyc = 0;
        rdy_low = 1'b1;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            tick;
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
                in_valid = 1'b0;
            end else if (in_ready !== 1'b0) begin
                rdy_low = 1'b0;
            end
        end
        in_valid = 1'b0;
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " result"}, 32'(result), 32'(r_sat));
        check({name, " result_nosat"}, 32'(result0), 32'(r_nosat));
        check({name, " mem_msw"}, 32'(mem_img[12]), 32'(r_sat[15:8]));
        check({name, " mem_lsw"}, 32'(mem_img[13]), 32'(r_sat[7:0]));
        check({name, " write_count"}, 32'(wr_cnt), 32'd2);
        check({name, " ready_low_busy"}, 32'(rdy_low), 32'd1);
        tick;
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] rs, rn;
        int          lat, e, m;
        bit          s;
        int          wr_before;
        bit          done_seen;

        tbl[0]  = '{"basic",      1'b0, 6'd16, 14'b01_1000000100_00, 16'h4204, 16'h4204, 5};
        tbl[1]  = '{"carry_out",  1'b0, 6'd16, 14'b11_0000001000_00, 16'h4604, 16'h4604, 5};
        tbl[2]  = '{"left_norm",  1'b0, 6'd20, 14'b00_0010000000_00, 16'h4400, 16'h4400, 8};
        tbl[3]  = '{"tie_odd",    1'b0, 6'd15, 14'b01_0000000001_10, 16'h3C02, 16'h3C02, 5};
        tbl[4]  = '{"tie_even",   1'b0, 6'd15, 14'b01_0000000000_10, 16'h3C00, 16'h3C00, 5};
        tbl[5]  = '{"above_half", 1'b0, 6'd15, 14'b01_0000000000_11, 16'h3C01, 16'h3C01, 5};
        tbl[6]  = '{"ovf_pos",    1'b0, 6'd31, 14'b11_0000000000_00, 16'h7FFF, 16'h7C00, 5};
        tbl[7]  = '{"ovf_neg",    1'b1, 6'd31, 14'b11_0000000000_00, 16'hFFFF, 16'hFC00, 5};
        tbl[8]  = '{"zero_neg",   1'b1, 6'd9,  14'd0,                16'h0000, 16'h0000, 4};
        tbl[9]  = '{"denormal",   1'b0, 6'd2,  14'b00_0000000100_00, 16'h0010, 16'h0010, 7};
        tbl[10] = '{"round_carry",1'b0, 6'd15, 14'b01_1111111111_11, 16'h4000, 16'h4000, 5};
        tbl[11] = '{"round_ovf",  1'b0, 6'd30, 14'b01_1111111111_11, 16'h7FFF, 16'h7C00, 5};
        tbl[12] = '{"exp0_carry", 1'b0, 6'd0,  14'b10_0000000000_00, 16'h0400, 16'h0400, 5};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        repeat (3) tick;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 13; i++)
            run_op(tbl[i].name, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].r_sat, tbl[i].r_nosat, tbl[i].lat);

        // Abort a left-normalizing op with a one-cycle reset while in NORM
        in_sign  = 1'b0;
        in_exp   = 6'd20;
        in_mant  = 14'b00_0010000000_00;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        wr_before = wr_cnt;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort mem_we", 32'(mem_we), 32'd0);
        check("abort mem_addr", 32'(mem_addr), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort done", 32'(done), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("abort no_writes", 32'(wr_cnt - wr_before), 32'd0);
        check("abort no_done", 32'(done_seen), 32'd0);
        run_op("after_abort", 1'b0, 6'd16, 14'b01_1000000100_00, 16'h4204, 16'h4204, 5);

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom);
            e = $urandom_range(0, 63);
            m = $urandom_range(0, 16383) >> $urandom_range(0, 13);
            if ($urandom_range(0, 15) == 0) m = 0;
            model(s, e, m, 1'b1, rs, lat);
            model(s, e, m, 1'b0, rn, lat);
            run_op($sformatf("rand%0d", i), s, 6'(e), 14'(m), rs, rn, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
